// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: the ALU has strict priority, and external results are queued
// in a small FIFO. It also flags read hazards against queued writes and against the write in flight.
module reg_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          alu_we,
   input  logic [ADDR_WIDTH-1:0]         alu_addr,
   input  logic [DATA_WIDTH-1:0]         alu_data,
   input  logic                          ext_valid,
   output logic                          ext_ready,
   input  logic [ADDR_WIDTH-1:0]         ext_addr,
   input  logic [DATA_WIDTH-1:0]         ext_data,
   input  logic [ADDR_WIDTH-1:0]         read_addr_0,
   input  logic [ADDR_WIDTH-1:0]         read_addr_1,
   output logic                          hazard_0,
   output logic                          hazard_1,
   output logic                          write_enable,
   output logic [ADDR_WIDTH-1:0]         write_addr,
   output logic [DATA_WIDTH-1:0]         write_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] addr_mem_r [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  push_s;
   logic                  pop_s;
   logic [PTR_W-1:0]      offset_s [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] slot_valid_s;
   logic                  write_enable_r;
   logic [ADDR_WIDTH-1:0] write_addr_r;
   logic [DATA_WIDTH-1:0] write_data_r;
   logic                  hazard_0_s;
   logic                  hazard_1_s;

   // The pop decision uses the registered count, so an entry pushed on this edge waits one more edge.
   assign ext_ready    = ~reset & (count_r < FULL_CNT);
   assign push_s       = ext_valid & ext_ready;
   assign pop_s        = ~alu_we & (count_r != {CNT_W{1'b0}});
   assign fifo_count   = count_r;
   assign write_enable = write_enable_r;
   assign write_addr   = write_addr_r;
   assign write_data   = write_data_r;
   assign hazard_0     = hazard_0_s;
   assign hazard_1     = hazard_1_s;

   // FIFO pointers and occupancy; power-of-two depth makes the pointer wrap implicit.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // FIFO storage; contents need no reset because validity comes from the pointers.
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_mem_r[wr_ptr_r] <= ext_addr;
         data_mem_r[wr_ptr_r] <= ext_data;
      end
   end

   // Registered writeback port: reset, then ALU, then the FIFO head, otherwise idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         write_enable_r <= 1'b0;
         write_addr_r   <= {ADDR_WIDTH{1'b0}};
         write_data_r   <= {DATA_WIDTH{1'b0}};
      end else if (alu_we) begin
         write_enable_r <= 1'b1;
         write_addr_r   <= alu_addr;
         write_data_r   <= alu_data;
      end else if (pop_s) begin
         write_enable_r <= 1'b1;
         write_addr_r   <= addr_mem_r[rd_ptr_r];
         write_data_r   <= data_mem_r[rd_ptr_r];
      end else begin
         write_enable_r <= 1'b0;
      end
   end

   // A slot holds a live entry when its distance from the read pointer is below the count.
   always_comb begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         offset_s[i]     = PTR_W'(i) - rd_ptr_r;
         slot_valid_s[i] = ({1'b0, offset_s[i]} < count_r);
      end
   end

   // Hazard flags: any live queued destination, or the write currently on the port.
   always_comb begin
      hazard_0_s = write_enable_r & (write_addr_r == read_addr_0);
      hazard_1_s = write_enable_r & (write_addr_r == read_addr_1);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         hazard_0_s = hazard_0_s | (slot_valid_s[i] & (addr_mem_r[i] == read_addr_0));
         hazard_1_s = hazard_1_s | (slot_valid_s[i] & (addr_mem_r[i] == read_addr_1));
      end
      hazard_0_s = hazard_0_s & ~reset;
      hazard_1_s = hazard_1_s & ~reset;
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus a randomized run,
// all compared against a queue-based model of the writeback arbiter.
module tb_reg_wb_arbiter;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset, alu_we, ext_valid, ext_ready;
   logic [AW-1:0] alu_addr, ext_addr, read_addr_0, read_addr_1, write_addr;
   logic [DW-1:0] alu_data, ext_data, write_data;
   logic          hazard_0, hazard_1, write_enable;
   logic [2:0]    fifo_count;

   int n_vec = 0;
   int n_err = 0;

   logic [AW-1:0] mq_addr [$];
   logic [DW-1:0] mq_data [$];
   logic          m_we   = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;

   always #5 clk = ~clk;

   reg_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data),
      .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_addr(ext_addr), .ext_data(ext_data),
      .read_addr_0(read_addr_0), .read_addr_1(read_addr_1),
      .hazard_0(hazard_0), .hazard_1(hazard_1),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .fifo_count(fifo_count)
   );

   function automatic logic m_ready();
      return !reset && (mq_addr.size() < DEPTH);
   endfunction

   function automatic logic m_hazard(input logic [AW-1:0] ra);
      if (reset) return 1'b0;
      foreach (mq_addr[k]) if (mq_addr[k] == ra) return 1'b1;
      return m_we && (m_addr == ra);
   endfunction

   // Drive one cycle of inputs, advance the model on the edge, return at the falling edge.
   task automatic cycle(input logic rst, input logic awe, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
      logic acc;
      reset = rst; alu_we = awe; alu_addr = aa; alu_data = ad;
      ext_valid = ev; ext_addr = ea; ext_data = ed;
      @(posedge clk);
      if (rst) begin
         mq_addr.delete(); mq_data.delete();
         m_we = 1'b0; m_addr = '0; m_data = '0;
      end else begin
         acc = ev && (mq_addr.size() < DEPTH);
         if (awe) begin
            m_we = 1'b1; m_addr = aa; m_data = ad;
         end else if (mq_addr.size() > 0) begin
            m_we = 1'b1; m_addr = mq_addr.pop_front(); m_data = mq_data.pop_front();
         end else begin
            m_we = 1'b0;
         end
         if (acc) begin
            mq_addr.push_back(ea); mq_data.push_back(ed);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic test_reset();
      read_addr_0 = 4'd0; read_addr_1 = 4'd9;
      cycle(1'b1, 1'b1, 4'd6, 32'h1111, 1'b1, 4'd9, 32'h2222);
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we got=%0h exp=0", write_enable); end
      n_vec++; if (write_addr !== 4'd0) begin n_err++; $display("FAIL reset_addr got=%0h exp=0", write_addr); end
      n_vec++; if (write_data !== 32'd0) begin n_err++; $display("FAIL reset_data got=%0h exp=0", write_data); end
      n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
      n_vec++; if (ext_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%0b exp=0", ext_ready); end
      n_vec++; if (hazard_0 !== 1'b0 || hazard_1 !== 1'b0) begin n_err++; $display("FAIL reset_hazard got=%0b%0b exp=00", hazard_0, hazard_1); end
      idle();
      n_vec++; if (ext_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got=%0b exp=1", ext_ready); end
   endtask

   task automatic test_alu_only();
      cycle(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, '0, '0);
      n_vec++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL alu_we got=%0b exp=1", write_enable); end
      n_vec++; if (write_addr !== 4'd3) begin n_err++; $display("FAIL alu_addr got=%0h exp=3", write_addr); end
      n_vec++; if (write_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_data got=%0h exp=deadbeef", write_data); end
      idle();
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL alu_we_off got=%0b exp=0", write_enable); end
      n_vec++; if (write_addr !== 4'd3) begin n_err++; $display("FAIL alu_addr_hold got=%0h exp=3", write_addr); end
   endtask

   task automatic test_ext_only();
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 4'd5, 32'h12);
      n_vec++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL ext_count1 got=%0d exp=1", fifo_count); end
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL ext_early_we got=%0b exp=0", write_enable); end
      idle();
      n_vec++; if (write_enable !== 1'b1 || write_addr !== 4'd5 || write_data !== 32'h12) begin
         n_err++; $display("FAIL ext_write got=%0b/%0h/%0h exp=1/5/12", write_enable, write_addr, write_data); end
      n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL ext_count0 got=%0d exp=0", fifo_count); end
      idle();
   endtask

   task automatic test_priority();
      read_addr_0 = 4'd7; read_addr_1 = 4'd2;
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 4'd7, 32'h77);
      n_vec++; if (hazard_0 !== 1'b1) begin n_err++; $display("FAIL prio_hz_queued got=%0b exp=1", hazard_0); end
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, 4'd2, 32'h200 + k, 1'b0, '0, '0);
         n_vec++; if (write_enable !== 1'b1 || write_addr !== 4'd2) begin n_err++; $display("FAIL prio_alu%0d got=%0b/%0h exp=1/2", k, write_enable, write_addr); end
         n_vec++; if (hazard_0 !== 1'b1 || hazard_1 !== 1'b1) begin n_err++; $display("FAIL prio_hz%0d got=%0b%0b exp=11", k, hazard_0, hazard_1); end
      end
      idle();
      n_vec++; if (write_enable !== 1'b1 || write_addr !== 4'd7 || write_data !== 32'h77) begin
         n_err++; $display("FAIL prio_ext got=%0b/%0h/%0h exp=1/7/77", write_enable, write_addr, write_data); end
      n_vec++; if (hazard_0 !== 1'b1 || hazard_1 !== 1'b0) begin n_err++; $display("FAIL prio_hz_port got=%0b%0b exp=10", hazard_0, hazard_1); end
      idle();
      n_vec++; if (hazard_0 !== 1'b0) begin n_err++; $display("FAIL prio_hz_clear got=%0b exp=0", hazard_0); end
   endtask

   task automatic test_full();
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b1, 4'd1, 32'h1, 1'b1, 4'(8 + k), 32'(100 + k));
         n_vec++; if (fifo_count !== 3'((k < 4) ? k + 1 : 4)) begin n_err++; $display("FAIL full_count%0d got=%0d exp=%0d", k, fifo_count, (k < 4) ? k + 1 : 4); end
      end
      n_vec++; if (ext_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%0b exp=0", ext_ready); end
      for (int k = 0; k < 4; k++) begin
         idle();
         n_vec++; if (write_enable !== 1'b1 || write_addr !== 4'(8 + k) || write_data !== 32'(100 + k)) begin
            n_err++; $display("FAIL full_drain%0d got=%0b/%0h/%0d exp=1/%0h/%0d", k, write_enable, write_addr, write_data, 8 + k, 100 + k); end
         n_vec++; if (ext_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_back%0d got=%0b exp=1", k, ext_ready); end
      end
      idle();
      n_vec++; if (write_enable !== 1'b0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL full_empty got=%0b/%0d exp=0/0", write_enable, fifo_count); end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] got_a [$];
      logic [DW-1:0] got_d [$];
      for (int k = 0; k < 13; k++) begin
         if (k < 10) cycle(1'b0, 1'b0, '0, '0, 1'b1, 4'(k), 32'(k));
         else idle();
         if (write_enable === 1'b1) begin got_a.push_back(write_addr); got_d.push_back(write_data); end
         n_vec++; if (fifo_count > 3'd4) begin n_err++; $display("FAIL wrap_count got=%0d exp<=4", fifo_count); end
      end
      n_vec++; if (got_a.size() != 10) begin n_err++; $display("FAIL wrap_num got=%0d exp=10", got_a.size()); end
      for (int k = 0; k < got_a.size() && k < 10; k++) begin
         n_vec++; if (got_a[k] !== 4'(k) || got_d[k] !== 32'(k)) begin n_err++; $display("FAIL wrap_order%0d got=%0h/%0h exp=%0h", k, got_a[k], got_d[k], k); end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 4'd0, 32'h0, 1'b1, 4'(12 + k), 32'hC0 + k);
      n_vec++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL mid_count got=%0d exp=3", fifo_count); end
      cycle(1'b1, 1'b1, 4'd4, 32'h4, 1'b1, 4'd15, 32'hF);
      n_vec++; if (fifo_count !== 3'd0 || write_enable !== 1'b0 || ext_ready !== 1'b0) begin
         n_err++; $display("FAIL mid_reset got=%0d/%0b/%0b exp=0/0/0", fifo_count, write_enable, ext_ready); end
      for (int k = 0; k < 5; k++) begin
         idle();
         n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL mid_ghost%0d got=%0b/%0h exp=0", k, write_enable, write_addr); end
      end
   endtask

   task automatic test_random();
      int pct;
      for (int k = 0; k < 600; k++) begin
         pct = ((k / 40) % 2 == 1) ? 85 : 25;
         read_addr_0 = 4'($urandom); read_addr_1 = 4'($urandom);
         cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 99) < pct), 4'($urandom), $urandom,
               ($urandom_range(0, 99) < 70), 4'($urandom), $urandom);
         n_vec++; if (write_enable !== m_we) begin n_err++; $display("FAIL rnd_we@%0d got=%0b exp=%0b", k, write_enable, m_we); end
         n_vec++; if (write_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr@%0d got=%0h exp=%0h", k, write_addr, m_addr); end
         n_vec++; if (write_data !== m_data) begin n_err++; $display("FAIL rnd_data@%0d got=%0h exp=%0h", k, write_data, m_data); end
         n_vec++; if (fifo_count !== 3'(mq_addr.size())) begin n_err++; $display("FAIL rnd_count@%0d got=%0d exp=%0d", k, fifo_count, mq_addr.size()); end
         n_vec++; if (ext_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready@%0d got=%0b exp=%0b", k, ext_ready, m_ready()); end
         n_vec++; if (hazard_0 !== m_hazard(read_addr_0)) begin n_err++; $display("FAIL rnd_hz0@%0d got=%0b exp=%0b", k, hazard_0, m_hazard(read_addr_0)); end
         n_vec++; if (hazard_1 !== m_hazard(read_addr_1)) begin n_err++; $display("FAIL rnd_hz1@%0d got=%0b exp=%0b", k, hazard_1, m_hazard(read_addr_1)); end
      end
   endtask

   initial begin
      reset = 1'b1; alu_we = 1'b0; alu_addr = '0; alu_data = '0;
      ext_valid = 1'b0; ext_addr = '0; ext_data = '0; read_addr_0 = '0; read_addr_1 = '0;
      @(negedge clk);
      test_reset();
      test_alu_only();
      test_ext_only();
      test_priority();
      test_full();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register address width (16 registers).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, external-writeback queue depth; power of two, at least 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-005 alu_we  in  1  ALU writeback strobe; no backpressure.
REQ-006 alu_addr  in  ADDR_WIDTH  ALU destination register.
REQ-007 alu_data  in  DATA_WIDTH  ALU result.
REQ-008 ext_valid  in  1  external (FPROC/sync) writeback request valid.
REQ-009 ext_ready  out  1  arbiter can accept an external request.
REQ-010 ext_addr  in  ADDR_WIDTH  external destination register.
REQ-011 ext_data  in  DATA_WIDTH  external result.
REQ-012 read_addr_0, read_addr_1  in  ADDR_WIDTH each  decoder source-register addresses, for hazard check.
REQ-013 hazard_0, hazard_1  out  1 each  the matching read address has a write in flight.
REQ-014 write_enable  out  1  register-file write strobe.
REQ-015 write_addr  out  ADDR_WIDTH  register-file write address.
REQ-016 write_data  out  DATA_WIDTH  register-file write data.
REQ-017 fifo_count  out  log2(FIFO_DEPTH)+1  current number of queued external entries.

Function
REQ-018 SHALL register write_enable, write_addr and write_data; they update on the clk edge after the winning source is selected.
REQ-019 SHALL give the ALU strict priority: if alu_we=1 at an edge, the next-cycle outputs SHALL be write_enable=1, write_addr=alu_addr, write_data=alu_data.
REQ-020 SHALL handle alu_we=0 with the FIFO non-empty by popping the head entry and presenting it on the write outputs next cycle with write_enable=1.
REQ-021 SHALL hold write_enable=0 on the next cycle when alu_we=0 and the FIFO is empty; write_addr and write_data then hold their previous values.
REQ-022 SHALL drive ext_ready=1 exactly when reset=0 and fifo_count<FIFO_DEPTH (combinational).
REQ-023 SHALL push ext_addr/ext_data into the FIFO on an edge where ext_valid=1 and ext_ready=1; a push SHALL NOT depend on ext_ready going low afterwards.
REQ-024 SHALL support push and pop on the same edge with fifo_count unchanged; ext_ready SHALL stay 0 when full even if a pop occurs that cycle.
REQ-025 SHALL make a pushed entry eligible for pop no earlier than the edge after its push, giving a minimum external latency of 2 cycles from accept to write_enable.
REQ-026 SHALL write FIFO entries in acceptance order; ALU writes pre-empt without reordering the FIFO.
REQ-027 SHALL implement FIFO pointers modulo FIFO_DEPTH with wrap-around; fifo_count SHALL never exceed FIFO_DEPTH or underflow.
REQ-028 SHALL assert hazard_N combinationally when read_addr_N equals the address of any valid FIFO entry, or equals write_addr while write_enable=1.
REQ-029 SHALL NOT include alu_addr in the hazard check; the decoder owns ALU forwarding.
REQ-030 SHALL not detect collisions between an ALU write and a queued FIFO entry to the same register; the later FIFO write overwrites, and the decoder avoids this using the hazard outputs.

Reset
REQ-031 SHALL, on an edge with reset=1, set fifo_count=0, read/write pointers=0, write_enable=0, write_addr=0 and write_data=0; queued entries are discarded.
REQ-032 SHALL hold ext_ready=0, hazard_0=0 and hazard_1=0 while reset=1.
REQ-033 SHALL give reset priority over simultaneous alu_we or ext_valid; inputs on a reset edge are dropped.
REQ-034 SHALL accept a request on the first edge after reset deasserts.

Verification
REQ-035 SHALL cover ALU only: alu_we=1, alu_addr=3, alu_data=0xDEADBEEF for one cycle -> next cycle write_enable=1, write_addr=3, write_data=0xDEADBEEF; the following cycle write_enable=0.
REQ-036 SHALL cover external only: ext_valid=1, addr=5, data=0x12 accepted at edge T -> write_enable=1, addr=5, data=0x12 in the cycle after edge T+1; fifo_count reads 1 then 0.
REQ-037 SHALL cover priority: ext entry addr=7 queued, then alu_we=1 addr=2 on 3 consecutive cycles -> writes to 2,2,2 then 7; hazard_0=1 for read_addr_0=7 throughout.
REQ-038 SHALL cover full: alu_we held 1, 5 ext requests offered -> 4 accepted, ext_ready=0, fifo_count=4; drop alu_we -> entries drained in order, one per cycle, ext_ready returns 1 after the first pop.
REQ-039 SHALL cover wrap-around: 10 ext requests (addr=i, data=i) streamed with alu_we=0 -> 10 in-order writes, no loss, fifo_count never above 4.
REQ-040 SHALL cover reset mid-operation: 3 queued entries, reset=1 for one cycle -> fifo_count=0, write_enable=0, no queued entry ever written afterwards.
